// File: rtl/diff_mc.sv
// Multi-channel ORDER-th backward differentiator with optional output saturation.
// Per-channel difference history feeds a 2-entry in-order output FIFO.
module diff_mc #(
    parameter int INPUT_WIDTH = 16,
    parameter int CHANNELS    = 4,
    parameter int ORDER       = 1,
    parameter int SATURATE    = 0,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int OW = (SATURATE != 0) ? INPUT_WIDTH : INPUT_WIDTH + ORDER
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic [CW-1:0]          in_chan,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OW-1:0]          out_data,
    output logic [CW-1:0]          out_chan,
    output logic                   out_sat
);
    localparam int W  = INPUT_WIDTH;
    localparam int FW = W + 3;
    localparam int EW = OW + CW + 1;
    localparam logic signed [FW-1:0] SMAX = {{(FW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [FW-1:0] SMIN = {{(FW-W+1){1'b1}}, {(W-1){1'b0}}};

    // Returns {clamped_flag, clamped_value} for a full-width difference.
    function automatic logic [OW:0] sat_fn(input logic signed [FW-1:0] v);
        if (v > SMAX) begin
            sat_fn = {1'b1, SMAX[OW-1:0]};
        end else if (v < SMIN) begin
            sat_fn = {1'b1, SMIN[OW-1:0]};
        end else begin
            sat_fn = {1'b0, v[OW-1:0]};
        end
    endfunction

    logic                 chan_ok_s;
    logic [CW-1:0]        idx_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic signed [FW-1:0] x_s, h0_s, h1_s, h2_s;
    logic signed [FW-1:0] d1_s, d2_s, d3_s, res_s;
    logic [OW-1:0]        data_s;
    logic                 sat_s;
    logic signed [W-1:0]  p0_r [CHANNELS];
    logic [EW-1:0]        mem_r [2];
    logic                 rd_ptr_r, wr_ptr_r;
    logic [1:0]           count_r;

    generate
        if ((1 << CW) == CHANNELS) begin : g_chan_full
            assign chan_ok_s = 1'b1;
        end else begin : g_chan_chk
            assign chan_ok_s = (in_chan < CW'(CHANNELS));
        end
    endgenerate

    assign idx_s    = chan_ok_s ? in_chan : {CW{1'b0}};
    assign in_ready = reset_n && (count_r != 2'd2);
    assign accept_s = in_valid && in_ready;
    assign push_s   = accept_s && chan_ok_s;
    assign pop_s    = (count_r != 2'd0) && out_ready;

    // A clear in the same cycle makes every history read as zero.
    assign x_s  = FW'($signed(in_data));
    assign h0_s = clear ? {FW{1'b0}} : FW'(p0_r[idx_s]);
    assign d1_s = x_s - h0_s;
    assign d2_s = d1_s - h1_s;
    assign d3_s = d2_s - h2_s;
    assign res_s = (ORDER == 1) ? d1_s : ((ORDER == 2) ? d2_s : d3_s);

    // Output word formation: clamp when saturating, otherwise exact result.
    always_comb begin
        data_s = {OW{1'b0}};
        sat_s  = 1'b0;
        if (SATURATE != 0) begin
            {sat_s, data_s} = sat_fn(res_s);
        end else begin
            data_s = res_s[OW-1:0];
            sat_s  = 1'b0;
        end
    end

    // Last-sample history per channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) p0_r[c] <= {W{1'b0}};
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push_s && (idx_s == CW'(c))) p0_r[c] <= $signed(in_data);
                else if (clear)                   p0_r[c] <= {W{1'b0}};
                else                              p0_r[c] <= p0_r[c];
            end
        end
    end

    generate
        if (ORDER >= 2) begin : g_p1
            logic signed [W:0] p1_r [CHANNELS];
            assign h1_s = clear ? {FW{1'b0}} : FW'(p1_r[idx_s]);
            // Last first-difference history per channel.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int c = 0; c < CHANNELS; c++) p1_r[c] <= {(W+1){1'b0}};
                end else begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (push_s && (idx_s == CW'(c))) p1_r[c] <= d1_s[W:0];
                        else if (clear)                   p1_r[c] <= {(W+1){1'b0}};
                        else                              p1_r[c] <= p1_r[c];
                    end
                end
            end
        end else begin : g_no_p1
            assign h1_s = {FW{1'b0}};
        end

        if (ORDER >= 3) begin : g_p2
            logic signed [W+1:0] p2_r [CHANNELS];
            assign h2_s = clear ? {FW{1'b0}} : FW'(p2_r[idx_s]);
            // Last second-difference history per channel.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int c = 0; c < CHANNELS; c++) p2_r[c] <= {(W+2){1'b0}};
                end else begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (push_s && (idx_s == CW'(c))) p2_r[c] <= d2_s[W+1:0];
                        else if (clear)                   p2_r[c] <= {(W+2){1'b0}};
                        else                              p2_r[c] <= p2_r[c];
                    end
                end
            end
        end else begin : g_no_p2
            assign h2_s = {FW{1'b0}};
        end
    endgenerate

    // Two-entry output FIFO; clear does not touch it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_r[0] <= {EW{1'b0}};
            mem_r[1] <= {EW{1'b0}};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {sat_s, idx_s, data_s};
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign out_valid = (count_r != 2'd0);
    assign {out_sat, out_chan, out_data} = mem_r[rd_ptr_r];
endmodule

// File: tb/tb_diff_mc.sv
// Scoreboard bench for diff_mc: five instances (order 1/2/3, saturating, 3 channels)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_diff_mc;
    typedef struct {int data; int chan; logic sat;} exp_t;

    int total = 0;
    int bad   = 0;
    exp_t qa[$], qb[$], qc[$], qs[$], qr[$];

    logic        clk = 1'b0;
    logic        reset_n, clear, in_valid, out_ready;
    logic [15:0] in_data;
    logic [1:0]  in_chan;

    logic rdy_a, ov_a, os_a; logic [16:0] od_a; logic [1:0] oc_a;
    logic rdy_b, ov_b, os_b; logic [17:0] od_b; logic [1:0] oc_b;
    logic rdy_c, ov_c, os_c; logic [18:0] od_c; logic [1:0] oc_c;
    logic rdy_s, ov_s, os_s; logic [15:0] od_s; logic [1:0] oc_s;
    logic rdy_r, ov_r, os_r; logic [16:0] od_r; logic [1:0] oc_r;

    always #5 clk = ~clk;

    diff_mc #(.INPUT_WIDTH(16), .CHANNELS(4), .ORDER(1), .SATURATE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .in_chan(in_chan), .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .out_chan(oc_a), .out_sat(os_a));
    diff_mc #(.INPUT_WIDTH(16), .CHANNELS(4), .ORDER(2), .SATURATE(0)) u_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .in_chan(in_chan), .out_valid(ov_b), .out_ready(out_ready),
        .out_data(od_b), .out_chan(oc_b), .out_sat(os_b));
    diff_mc #(.INPUT_WIDTH(16), .CHANNELS(4), .ORDER(3), .SATURATE(0)) u_c (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data), .in_chan(in_chan), .out_valid(ov_c), .out_ready(out_ready),
        .out_data(od_c), .out_chan(oc_c), .out_sat(os_c));
    diff_mc #(.INPUT_WIDTH(16), .CHANNELS(4), .ORDER(1), .SATURATE(1)) u_s (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_s),
        .in_data(in_data), .in_chan(in_chan), .out_valid(ov_s), .out_ready(out_ready),
        .out_data(od_s), .out_chan(oc_s), .out_sat(os_s));
    diff_mc #(.INPUT_WIDTH(16), .CHANNELS(3), .ORDER(1), .SATURATE(0)) u_r (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_r),
        .in_data(in_data), .in_chan(in_chan), .out_valid(ov_r), .out_ready(out_ready),
        .out_data(od_r), .out_chan(oc_r), .out_sat(os_r));

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_chan = 2'd0; in_data = 16'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        qa.delete(); qb.delete(); qc.delete(); qs.delete(); qr.delete();
        cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_chan = 2'd0; in_data = 16'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rdy_a !== 1'b0 || ov_a !== 1'b0 || od_a !== 17'd0 || oc_a !== 2'd0 || os_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%0d c=%0d s=%b, want all 0", rdy_a, ov_a, od_a, oc_a, os_a);
        end
        total++;
        if (ov_s !== 1'b0 || od_s !== 16'd0 || os_s !== 1'b0) begin
            bad++;
            $display("FAIL reset_sat_inst: got v=%b d=%0d s=%b, want 0 0 0", ov_s, od_s, os_s);
        end
        reset_n = 1'b1;
        cycle();
        total++;
        if (rdy_a !== 1'b1 || ov_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", rdy_a, ov_a);
        end
    endtask

    task automatic test_order1();
        int v[3] = '{5, 8, 3};
        int e[3] = '{5, 3, -5};
        exp_t h;
        int act;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_chan = 2'd0; in_data = 16'(v[i]);
            qa.push_back('{e[i], 0, 1'b0});
            cycle();
            h = qa.pop_front();
            act = $signed(od_a);
            total++;
            if (ov_a !== 1'b1 || act !== h.data || int'(oc_a) !== h.chan) begin
                bad++;
                $display("FAIL order1[%0d]: got v=%b d=%0d c=%0d, want v=1 d=%0d c=%0d", i, ov_a, act, oc_a, h.data, h.chan);
            end
        end
        in_valid = 1'b0;
        cycle();
        total++;
        if (ov_a !== 1'b0) begin
            bad++;
            $display("FAIL order1_idle: got out_valid=%b, want 0", ov_a);
        end
    endtask

    task automatic test_order23();
        int v[4]  = '{1, 4, 9, 16};
        int e2[4] = '{1, 2, 2, 2};
        int e3[4] = '{1, 1, 0, 0};
        exp_t hb, hc;
        int ab, ac;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_chan = 2'd1; in_data = 16'(v[i]);
            qb.push_back('{e2[i], 1, 1'b0});
            qc.push_back('{e3[i], 1, 1'b0});
            cycle();
            hb = qb.pop_front(); hc = qc.pop_front();
            ab = $signed(od_b); ac = $signed(od_c);
            total++;
            if (ov_b !== 1'b1 || ab !== hb.data || int'(oc_b) !== hb.chan) begin
                bad++;
                $display("FAIL order2[%0d]: got v=%b d=%0d c=%0d, want d=%0d c=%0d", i, ov_b, ab, oc_b, hb.data, hb.chan);
            end
            total++;
            if (ov_c !== 1'b1 || ac !== hc.data || int'(oc_c) !== hc.chan) begin
                bad++;
                $display("FAIL order3[%0d]: got v=%b d=%0d c=%0d, want d=%0d c=%0d", i, ov_c, ac, oc_c, hc.data, hc.chan);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_interleave();
        int ch[6] = '{0, 1, 0, 3, 2, 0};
        int v[6]  = '{10, 100, 15, -7, 50, 20};
        int ea[6] = '{10, 100, 5, -7, 50, 5};
        exp_t h;
        int act;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                in_valid = 1'b1; in_chan = 2'(ch[i]); in_data = 16'(v[i]);
                qa.push_back('{ea[i], ch[i], 1'b0});
                if (ch[i] < 3) qr.push_back('{ea[i], ch[i], 1'b0});
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (ov_a === 1'b1) begin
                total++;
                act = $signed(od_a);
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL interleave_a_extra: got d=%0d c=%0d, want no word", act, oc_a);
                end else begin
                    h = qa.pop_front();
                    if (act !== h.data || int'(oc_a) !== h.chan) begin
                        bad++;
                        $display("FAIL interleave_a: got d=%0d c=%0d, want d=%0d c=%0d", act, oc_a, h.data, h.chan);
                    end
                end
            end
            if (ov_r === 1'b1) begin
                total++;
                act = $signed(od_r);
                if (qr.size() == 0) begin
                    bad++;
                    $display("FAIL interleave_r_extra: got d=%0d c=%0d, want no word", act, oc_r);
                end else begin
                    h = qr.pop_front();
                    if (act !== h.data || int'(oc_r) !== h.chan) begin
                        bad++;
                        $display("FAIL interleave_r: got d=%0d c=%0d, want d=%0d c=%0d", act, oc_r, h.data, h.chan);
                    end
                end
            end
        end
        total++;
        if (qa.size() != 0 || qr.size() != 0) begin
            bad++;
            $display("FAIL interleave_count: got missing a=%0d r=%0d, want 0 0", qa.size(), qr.size());
        end
    endtask

    task automatic test_saturate();
        int v[3]  = '{-32768, 32767, -32768};
        int ea[3] = '{-32768, 65535, -65535};
        int es[3] = '{-32768, 32767, -32768};
        logic ss[3] = '{1'b0, 1'b1, 1'b1};
        exp_t ha, hs;
        int aa, as_;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_chan = 2'd0; in_data = 16'(v[i]);
            qa.push_back('{ea[i], 0, 1'b0});
            qs.push_back('{es[i], 0, ss[i]});
            cycle();
            ha = qa.pop_front(); hs = qs.pop_front();
            aa = $signed(od_a); as_ = $signed(od_s);
            total++;
            if (ov_s !== 1'b1 || as_ !== hs.data || os_s !== hs.sat) begin
                bad++;
                $display("FAIL sat_on[%0d]: got v=%b d=%0d sat=%b, want d=%0d sat=%b", i, ov_s, as_, os_s, hs.data, hs.sat);
            end
            total++;
            if (ov_a !== 1'b1 || aa !== ha.data || os_a !== 1'b0) begin
                bad++;
                $display("FAIL sat_off[%0d]: got v=%b d=%0d sat=%b, want d=%0d sat=0", i, ov_a, aa, os_a, ha.data);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int prev, nxt, acc, act;
        logic will;
        exp_t h;
        apply_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_chan = 2'd0;
        prev = 0; nxt = 1; acc = 0;
        for (int k = 0; k < 4; k++) begin
            in_data = 16'(nxt);
            will = rdy_a;
            cycle();
            if (will) begin
                acc++;
                qa.push_back('{nxt - prev, 0, 1'b0});
                prev = nxt; nxt++;
            end
            if (acc > 0) begin
                total++;
                act = $signed(od_a);
                if (ov_a !== 1'b1 || act !== qa[0].data || oc_a !== 2'd0) begin
                    bad++;
                    $display("FAIL bp_hold[%0d]: got v=%b d=%0d c=%0d, want v=1 d=%0d c=0", k, ov_a, act, oc_a, qa[0].data);
                end
            end
        end
        total++;
        if (acc != 2) begin
            bad++;
            $display("FAIL bp_accepted: got %0d, want 2", acc);
        end
        total++;
        if (rdy_a !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready: got in_ready=%b, want 0", rdy_a);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (ov_a === 1'b1) begin
                total++;
                act = $signed(od_a);
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL bp_drain_extra: got d=%0d, want no word", act);
                end else begin
                    h = qa.pop_front();
                    if (act !== h.data) begin
                        bad++;
                        $display("FAIL bp_drain: got d=%0d, want d=%0d", act, h.data);
                    end
                end
            end
            cycle();
        end
        total++;
        if (qa.size() != 0 || ov_a !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain_done: got left=%0d v=%b, want 0 0", qa.size(), ov_a);
        end
        in_valid = 1'b1; in_data = 16'(nxt);
        cycle();
        in_valid = 1'b0;
        act = $signed(od_a);
        total++;
        if (ov_a !== 1'b1 || act !== nxt - prev) begin
            bad++;
            $display("FAIL bp_resume: got v=%b d=%0d, want v=1 d=%0d", ov_a, act, nxt - prev);
        end
    endtask

    task automatic test_clear();
        int ch[5]   = '{0, 1, 0, 1, 0};
        int v[5]    = '{20, 30, 25, 31, 26};
        logic cl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int e[5]    = '{20, 30, 25, 31, 1};
        exp_t h;
        int act;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_chan = 2'(ch[i]); in_data = 16'(v[i]); clear = cl[i];
            qa.push_back('{e[i], ch[i], 1'b0});
            cycle();
            clear = 1'b0;
            h = qa.pop_front();
            act = $signed(od_a);
            total++;
            if (ov_a !== 1'b1 || act !== h.data || int'(oc_a) !== h.chan) begin
                bad++;
                $display("FAIL clear[%0d]: got v=%b d=%0d c=%0d, want d=%0d c=%0d", i, ov_a, act, oc_a, h.data, h.chan);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int act;
        apply_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_chan = 2'd0;
        in_data = 16'd11; cycle();
        in_data = 16'd12; cycle();
        in_valid = 1'b0;
        total++;
        if (ov_a !== 1'b1 || rdy_a !== 1'b0) begin
            bad++;
            $display("FAIL rmid_full: got v=%b rdy=%b, want v=1 rdy=0", ov_a, rdy_a);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (ov_a !== 1'b0 || od_a !== 17'd0 || oc_a !== 2'd0 || rdy_a !== 1'b0) begin
            bad++;
            $display("FAIL rmid_flush: got v=%b d=%0d c=%0d rdy=%b, want 0 0 0 0", ov_a, od_a, oc_a, rdy_a);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        cycle();
        out_ready = 1'b1; in_valid = 1'b1; in_chan = 2'd0; in_data = 16'd7;
        cycle();
        in_valid = 1'b0;
        act = $signed(od_a);
        total++;
        if (ov_a !== 1'b1 || act !== 7) begin
            bad++;
            $display("FAIL rmid_after: got v=%b d=%0d, want v=1 d=7", ov_a, act);
        end
    endtask

    initial begin
        test_reset();
        test_order1();
        test_order23();
        test_interleave();
        test_saturate();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
